counter_ctrl: RTL and testbench

- Run-control sequencer for the hex/BCD up-counter pair and its output mux.
- Generates the shared counter enable from a clock prescaler and handles run/stop/single-step commands.
- Issues a clear pulse to the counters and drives the hex/BCD display select.
- Sits between the debounced board buttons/switches and the counter datapath. Counter value is fed back for wrap detection.

---
 rtl/counter_ctrl.sv | 87 ++++++++
 tb/tb_counter_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: run/stop/single-step sequencer, prescaled enable, clear and hex/BCD select.
// Optional auto-swap of the select after SWAP_WRAPS wraps: define COUNTER_CTRL_AUTOSWAP_EN.
module counter_ctrl #(
  parameter int DIV_WIDTH  = 27,
  parameter int DIV_MAX    = 99_999_999,
  parameter int SWAP_WRAPS = 2
) (
  input  logic       counter_ctrl_clk,
  input  logic       counter_ctrl_rst,
  input  logic       counter_ctrl_start,
  input  logic       counter_ctrl_stop,
  input  logic       counter_ctrl_step,
  input  logic       counter_ctrl_mode,
  input  logic [3:0] counter_ctrl_count,
  output logic       counter_ctrl_en,
  output logic       counter_ctrl_clr,
  output logic       counter_ctrl_sel,
  output logic [1:0] counter_ctrl_state,
  output logic [3:0] counter_ctrl_wraps
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, STEP = 2'b11} state_t;
  localparam logic [DIV_WIDTH-1:0] DIV_TOP = DIV_WIDTH'(DIV_MAX);
  if (SWAP_WRAPS < 1 || SWAP_WRAPS > 15) begin : g_bad_swap
    $error("SWAP_WRAPS must be in 1..15");
  end
  state_t state, state_nx;
  logic [DIV_WIDTH-1:0] presc;
  logic prev_start, prev_stop, prev_step;
  logic stop_ev, start_ev, step_ev;
  logic en, tick, pause_stop, clr_nx, sel_nx, sel, clr;
  logic [3:0] wraps, wraps_nx;
  // Stop dominates; a losing event in the same cycle is dropped, not deferred.
  assign stop_ev  = counter_ctrl_stop & ~prev_stop;
  assign start_ev = counter_ctrl_start & ~prev_start & ~stop_ev;
  assign step_ev  = counter_ctrl_step & ~prev_step & ~stop_ev & ~start_ev;
  always_ff @(posedge counter_ctrl_clk or posedge counter_ctrl_rst)
    if (counter_ctrl_rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start_ev ? RUN : step_ev ? STEP : IDLE;
      RUN:     state_nx = stop_ev ? PAUSE : RUN;
      PAUSE:   state_nx = stop_ev ? IDLE : start_ev ? RUN : step_ev ? STEP : PAUSE;
      default: state_nx = PAUSE;
    endcase
    en = (state == RUN && presc == DIV_TOP) || state == STEP;
    pause_stop = state == PAUSE && stop_ev;
  end
  assign tick = en && counter_ctrl_count == (sel ? 4'd9 : 4'd15);
`ifdef COUNTER_CTRL_AUTOSWAP_EN
  logic swap;
  logic [3:0] wraps_inc;
  assign wraps_inc = wraps + 4'd1;
  assign swap      = state == RUN && tick && wraps_inc == 4'(SWAP_WRAPS);
  assign sel_nx    = swap ? ~sel : state == RUN ? sel : counter_ctrl_mode;
  assign clr_nx    = pause_stop | swap;
`else
  assign sel_nx = counter_ctrl_mode;
  assign clr_nx = pause_stop;
`endif
  // Any select change restarts the wrap count, as does a clear.
  assign wraps_nx = (clr_nx || sel_nx != sel) ? 4'd0 : wraps + {3'b000, tick};
  always_ff @(posedge counter_ctrl_clk or posedge counter_ctrl_rst)
    if (counter_ctrl_rst) begin
      presc      <= '0;
      prev_start <= 1'b0;
      prev_stop  <= 1'b0;
      prev_step  <= 1'b0;
      sel        <= 1'b0;
      clr        <= 1'b0;
      wraps      <= 4'd0;
    end else begin
      presc      <= (state == RUN && state_nx == RUN && presc != DIV_TOP) ? presc + DIV_WIDTH'(1) : '0;
      prev_start <= counter_ctrl_start;
      prev_stop  <= counter_ctrl_stop;
      prev_step  <= counter_ctrl_step;
      sel        <= sel_nx;
      clr        <= clr_nx;
      wraps      <= wraps_nx;
    end
  assign counter_ctrl_en    = en;
  assign counter_ctrl_clr   = clr;
  assign counter_ctrl_sel   = sel;
  assign counter_ctrl_state = state;
  assign counter_ctrl_wraps = wraps;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed stimulus for counter_ctrl (DIV_MAX=3) with a cycle-tagged scoreboard.
module tb_counter_ctrl;
  logic clk, rst, start, stop, step, mode;
  logic [3:0] count;
  logic en, clr, sel;
  logic [1:0] state;
  logic [3:0] wraps;
  counter_ctrl #(.DIV_WIDTH(27), .DIV_MAX(3), .SWAP_WRAPS(2)) dut (
    .counter_ctrl_clk(clk),
    .counter_ctrl_rst(rst),
    .counter_ctrl_start(start),
    .counter_ctrl_stop(stop),
    .counter_ctrl_step(step),
    .counter_ctrl_mode(mode),
    .counter_ctrl_count(count),
    .counter_ctrl_en(en),
    .counter_ctrl_clr(clr),
    .counter_ctrl_sel(sel),
    .counter_ctrl_state(state),
    .counter_ctrl_wraps(wraps)
  );
  typedef struct {
    int cyc;
    string name;
    logic [8:0] v;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: outputs are sampled mid-cycle; {en,clr,sel,state,wraps} vs the entry for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [8:0] got;
      e = q.pop_front();
      got = {en, clr, sel, state, wraps};
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: expected at cycle %0d, unchecked until cycle %0d", e.name, e.cyc, cyc);
      end else if (got !== e.v) begin
        bad++;
        $display("FAIL %s cyc=%0d: got en=%b clr=%b sel=%b state=%b wraps=%0d, want en=%b clr=%b sel=%b state=%b wraps=%0d",
                 e.name, cyc, got[8], got[7], got[6], got[5:4], got[3:0], e.v[8], e.v[7], e.v[6], e.v[5:4], e.v[3:0]);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_now(input string n, input logic e, input logic c, input logic s,
                            input logic [1:0] st, input logic [3:0] w);
    exp_t x;
    x.cyc = cyc;
    x.name = n;
    x.v = {e, c, s, st, w};
    q.push_back(x);
    tick();
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; mode = 1'b0; count = 4'd0;
    tick();
    expect_now("reset", 0, 0, 0, 2'd0, 4'd0);
    rst = 1'b0; start = 1'b1;
    expect_now("idle_before_start", 0, 0, 0, 2'd0, 4'd0);
    for (int k = 0; k < 11; k++) expect_now("run_en_period", (k % 4) == 3, 0, 0, 2'd1, 4'd0);
    rst = 1'b1; start = 1'b0;
    expect_now("async_rst_mid_run", 0, 0, 0, 2'd0, 4'd0);
    rst = 1'b0; start = 1'b1;
    expect_now("idle_after_rst", 0, 0, 0, 2'd0, 4'd0);
    start = 1'b0;
    expect_now("run_again", 0, 0, 0, 2'd1, 4'd0);
    stop = 1'b1;
    expect_now("run_before_stop", 0, 0, 0, 2'd1, 4'd0);
    expect_now("pause_entered", 0, 0, 0, 2'd2, 4'd0);
    stop = 1'b0;
    expect_now("pause_no_en", 0, 0, 0, 2'd2, 4'd0);
    expect_now("pause_hold", 0, 0, 0, 2'd2, 4'd0);
    stop = 1'b1;
    expect_now("pause_hold2", 0, 0, 0, 2'd2, 4'd0);
    expect_now("stop_clr_pulse", 0, 1, 0, 2'd0, 4'd0);
    expect_now("clr_single_cycle", 0, 0, 0, 2'd0, 4'd0);
    stop = 1'b0; step = 1'b1;
    expect_now("idle_before_step", 0, 0, 0, 2'd0, 4'd0);
    expect_now("step_from_idle", 1, 0, 0, 2'd3, 4'd0);
    step = 1'b0;
    expect_now("after_step_pause", 0, 0, 0, 2'd2, 4'd0);
    step = 1'b1;
    expect_now("pause_before_held_step", 0, 0, 0, 2'd2, 4'd0);
    expect_now("held_step_one_en", 1, 0, 0, 2'd3, 4'd0);
    for (int k = 0; k < 8; k++) expect_now("held_step_no_repeat", 0, 0, 0, 2'd2, 4'd0);
    step = 1'b0;
`ifdef COUNTER_CTRL_AUTOSWAP_EN
    count = 4'd15; start = 1'b1;
    expect_now("pause_before_swap_run", 0, 0, 0, 2'd2, 4'd0);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      mode = k[0];
      expect_now("autoswap", k < 8 && (k % 4) == 3, k == 8, k >= 8, 2'd1, (k >= 4 && k < 8) ? 4'd1 : 4'd0);
    end
`else
    mode = 1'b1; count = 4'd9; start = 1'b1;
    expect_now("pause_before_bcd", 0, 0, 0, 2'd2, 4'd0);
    start = 1'b0;
    for (int k = 0; k < 9; k++)
      expect_now("bcd_wraps", (k % 4) == 3, 0, 1, 2'd1, k < 4 ? 4'd0 : k < 8 ? 4'd1 : 4'd2);
    mode = 1'b0;
    expect_now("bcd_before_switch", 0, 0, 1, 2'd1, 4'd2);
    expect_now("hex_sel_wraps_cleared", 0, 0, 0, 2'd1, 4'd0);
    expect_now("hex_en_count9", 1, 0, 0, 2'd1, 4'd0);
    count = 4'd15;
    expect_now("hex_no_wrap_on_9", 0, 0, 0, 2'd1, 4'd0);
    expect_now("hex_run", 0, 0, 0, 2'd1, 4'd0);
    expect_now("hex_run2", 0, 0, 0, 2'd1, 4'd0);
    expect_now("hex_en_count15", 1, 0, 0, 2'd1, 4'd0);
    stop = 1'b1;
    expect_now("hex_wrap", 0, 0, 0, 2'd1, 4'd1);
    stop = 1'b0;
    expect_now("pause_keeps_wraps", 0, 0, 0, 2'd2, 4'd1);
    start = 1'b1; stop = 1'b1;
    expect_now("pause_before_both", 0, 0, 0, 2'd2, 4'd1);
    expect_now("stop_beats_start", 0, 1, 0, 2'd0, 4'd0);
    expect_now("no_run_entry", 0, 0, 0, 2'd0, 4'd0);
    expect_now("still_idle", 0, 0, 0, 2'd0, 4'd0);
`endif
    tick();
    if (q.size() != 0) begin
      bad += q.size();
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
